// File: rtl/spi_display_slave.sv
// spi_display_slave: oversampled SPI mode-0 slave receiver with status byte return on miso.
// Define SPI_SLAVE_FIFO_EN for a FIFO_DEPTH-entry receive FIFO with rd_en pop and sticky overflow.
module spi_display_slave #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  output logic       miso_o,
  input  logic [7:0] tx_status_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rd_en_i,
  output logic       frame_done_o,
  output logic       frame_err_o,
  output logic [7:0] byte_count_o,
  output logic       overflow_o
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [2:0] ss_q, sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] state_q, state_d, warm_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d, byte_count_q, byte_count_d, byte_w;
  logic       frame_done_q, frame_err_q, armed_q, start, wr;
  logic       sclk_rise, sclk_fall, ss_rise;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign byte_w    = {rx_shift_q, mosi_q[1]};
  assign wr        = state_q == SHIFT && sclk_rise && bit_cnt_q == 3'd7;
  // Starting on a low level behind an arm flag lets a fall during DONE still
  // start a frame, while a level that is already low after reset never does.
  assign start     = state_q == IDLE && armed_q && !ss_q[1];
  assign miso_o       = state_q == SHIFT && tx_shift_q[7];
  assign frame_done_o = frame_done_q;
  assign frame_err_o  = frame_err_q;
  assign byte_count_o = byte_count_q;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    byte_count_d = byte_count_q;
    if (start) begin
      state_d = SHIFT;
      tx_shift_d = tx_status_i;
      bit_cnt_d = 3'd0;
      byte_count_d = 8'd0;
    end else if (state_q == SHIFT) begin
      if (sclk_rise) begin
        rx_shift_d = byte_w[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (wr) begin
          byte_count_d = byte_count_q + 8'(byte_count_q != 8'hff);
          tx_shift_d = tx_status_i;
        end
      end else if (sclk_fall && bit_cnt_q != 3'd0) begin
        // Skip the fall after a reload so the new MSB is held for the next first sample.
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
      if (ss_rise) state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      state_q <= IDLE;
      warm_q <= 2'd0;
      armed_q <= 1'b0;
      bit_cnt_q <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 8'd0;
      byte_count_q <= 8'd0;
      frame_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ss_q <= {ss_q[1:0], ss_i};
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
      state_q <= state_d;
      warm_q <= warm_q == 2'd3 ? warm_q : warm_q + 2'd1;
      armed_q <= (warm_q == 2'd3 && ss_q[1]) || (armed_q && !start);
      bit_cnt_q <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      byte_count_q <= byte_count_d;
      frame_done_q <= state_q == DONE && bit_cnt_q == 3'd0;
      frame_err_q <= state_q == DONE && bit_cnt_q != 3'd0;
    end
  end
`ifdef SPI_SLAVE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic        overflow_q, empty, full, pop, push;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign pop   = rd_en_i && !empty;
  assign push  = wr && (!full || pop);
  assign rx_valid_o = !empty;
  assign rx_data_o  = empty ? 8'd0 : mem_q[rp_q[AW-1:0]];
  assign overflow_o = overflow_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= byte_w;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (wr && full && !pop) overflow_q <= 1'b1;
    end
  end
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q, unused_in;
  assign unused_in  = rd_en_i | (FIFO_DEPTH == 0);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign overflow_o = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= wr;
      if (wr) rx_data_q <= byte_w;
    end
  end
`endif
endmodule
